// File: rtl/mdu_pkg.sv
// Shared types for the RV64M multiply/divide unit: op encoding, decode fields and op-class helpers.
package mdu_pkg;

    localparam int MDU_XLEN    = 64;
    localparam int MDU_MUL_BPC = 4;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef struct packed {
        logic    muldiv;
        mdu_op_t mdu_op;
    } mdu_decode_t;

    function automatic logic mdu_is_div(input mdu_op_t op);
        return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    endfunction

    function automatic logic mdu_is_rem(input mdu_op_t op);
        return op inside {MDU_REM, MDU_REMU};
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// quotient_o/remainder_o carry the post-step values, so they are final in the cycle done_o is high.
module mdu_divider #(
    parameter int XLEN = 64,
    parameter int CW   = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [CW-1:0]   n_iter_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            done_o
);

    logic [XLEN-1:0] quo_q, rem_q, dsr_q;
    logic [XLEN-1:0] quo_d, rem_d;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic [XLEN:0]   trial, diff;
    logic            fits;

    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]};
        diff  = trial - {1'b0, dsr_q};
        fits  = ~diff[XLEN];
        rem_d = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], fits};
    end

    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;
    assign done_o      = busy_q && (cnt_q == CW'(1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            // Left-align a short dividend so the iteration always consumes from the top bit
            quo_q  <= dividend_i << (CW'(XLEN) - n_iter_i);
            rem_q  <= '0;
            dsr_q  <= divisor_i;
            cnt_q  <= n_iter_i;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle RV64M multiply/divide unit with valid/ready handshakes on both sides.
// state  | meaning
// IDLE   | ready for a new op
// MUL    | shift-add, MUL_BPC multiplier bits per cycle
// DIV    | waiting on mdu_divider
// DONE   | result held until out_ready_i
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN    = MDU_XLEN,
    parameter int MUL_BPC = MDU_MUL_BPC
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    mdu_op_t         op_q, op_d;
    logic            word_q, word_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   mcnt_q, mcnt_d;
    logic [XLEN-1:0] result_q, result_d;

    mdu_op_t         op_in;
    logic            sgn_a, sgn_b, sa, sb, is_rem_in, b_zero, ovf;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, fast_res;
    logic [CW-1:0]   n_div, n_mul;
    logic [PW-1:0]   acc_step, prod_s;
    logic [XLEN-1:0] mul_hi, mul_res, q_s, r_s, div_res;
    logic [XLEN-1:0] div_quo, div_rem;
    logic            div_start, div_done;

    function automatic logic [XLEN-1:0] fix_w(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Operand conditioning and fast-path detection for the accept cycle
    always_comb begin
        op_in     = mdu_op_t'(op_i);
        sgn_a     = !(op_in inside {MDU_MULHU, MDU_DIVU, MDU_REMU});
        sgn_b     = sgn_a && (op_in != MDU_MULHSU);
        a_ext     = word_i ? {{(XLEN-32){sgn_a & a_i[31]}}, a_i[31:0]} : a_i;
        b_ext     = word_i ? {{(XLEN-32){sgn_b & b_i[31]}}, b_i[31:0]} : b_i;
        sa        = sgn_a & a_ext[XLEN-1];
        sb        = sgn_b & b_ext[XLEN-1];
        a_mag     = sa ? -a_ext : a_ext;
        b_mag     = sb ? -b_ext : b_ext;
        is_rem_in = mdu_is_rem(op_in);
        b_zero    = (b_ext == '0);
        ovf       = sgn_a && (b_ext == '1) &&
                    (word_i ? (a_i[31:0] == 32'h8000_0000)
                            : (a_ext == {1'b1, {(XLEN-1){1'b0}}}));
        if (b_zero) fast_res = fix_w(is_rem_in ? a_i : '1, word_i);
        else        fast_res = fix_w(is_rem_in ? '0 : a_i, word_i);
        n_div     = word_i ? CW'(32) : CW'(XLEN);
        n_mul     = word_i ? CW'(32 / MUL_BPC) : CW'(XLEN / MUL_BPC);
    end

    always_comb begin
        acc_step = acc_q + mcand_q * PW'(mplier_q[MUL_BPC-1:0]);
        prod_s   = neg_q ? -acc_step : acc_step;
        mul_hi   = word_q ? {{(XLEN-32){1'b0}}, prod_s[63:32]} : prod_s[PW-1:XLEN];
        mul_res  = fix_w((op_q == MDU_MUL) ? prod_s[XLEN-1:0] : mul_hi, word_q);
        q_s      = neg_q ? -div_quo : div_quo;
        r_s      = neg_q ? -div_rem : div_rem;
        div_res  = fix_w(mdu_is_rem(op_q) ? r_s : q_s, word_q);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        word_d    = word_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        mcnt_d    = mcnt_q;
        result_d  = result_q;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i && !flush_i) begin
                    op_d   = op_in;
                    word_d = word_i;
                    neg_d  = is_rem_in ? sa : (sa ^ sb);
                    if (mdu_is_div(op_in)) begin
                        if (b_zero || ovf) begin
                            result_d = fast_res;
                            state_d  = S_DONE;
                        end else begin
                            div_start = 1'b1;
                            state_d   = S_DIV;
                        end
                    end else begin
                        mcand_d  = {{XLEN{1'b0}}, a_mag};
                        mplier_d = b_mag;
                        acc_d    = '0;
                        mcnt_d   = n_mul;
                        state_d  = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << MUL_BPC;
                mplier_d = mplier_q >> MUL_BPC;
                mcnt_d   = mcnt_q - CW'(1);
                if (mcnt_q == CW'(1)) begin
                    result_d = mul_res;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d   = S_IDLE;
            div_start = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            op_q     <= MDU_MUL;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mcnt_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mcnt_q   <= mcnt_d;
            result_q <= result_d;
        end
    end

    mdu_divider #(
        .XLEN(XLEN),
        .CW  (CW)
    ) u_divider (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (div_start),
        .n_iter_i   (n_div),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quotient_o (div_quo),
        .remainder_o(div_rem),
        .done_o     (div_done)
    );

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;

endmodule
